// File: rtl/sd_bd_fetch.sv
// sd_bd_fetch: consumer stage that sits directly after the buffer-descriptor (BD) store.
//
// The store publishes a free-slot count. While that count is below MAX_BD, at least one
// descriptor is waiting. This block reads the two words of each waiting descriptor over the
// store's strobe/acknowledge read port: the source buffer address comes first, then the SD
// block address. It offers the assembled descriptor to the transfer master with a
// valid/ready handshake. When the master reports done, it pulses a_cmp so the store can
// release the slot.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   en           fetch enable; checked only in IDLE, so a BD in flight always completes
//   free_bd      free-slot count from the BD store
//   re_s         one-cycle read strobe to the store
//   ack_o_s      read acknowledge; dat_out_s is valid while it is high
//   dat_out_s    descriptor word from the store
//   a_cmp        one-cycle pulse: current BD fully serviced, slot may be freed
//   xfr_valid    descriptor offered to the transfer master
//   xfr_ready    transfer master accepts the descriptor
//   xfr_src_addr source buffer address (word 0), holds its last latched value
//   xfr_blk_addr SD block address (word 1), holds its last latched value
//   xfr_done     one-cycle pulse: transfer finished
//   xfr_err      qualifies xfr_done: the transfer failed
//   err_clr      leaves the ERR state and clears fetch_err
//   busy         high in every state except IDLE and ERR
//   fetch_err    high while parked in ERR after a read-acknowledge timeout
//   err_cnt      saturating count of failed transfers
module sd_bd_fetch #(
  parameter int BD_SIZE     = 8,
  parameter int BD_WIDTH    = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [BD_WIDTH-1:0] free_bd,
  output logic                re_s,
  input  logic                ack_o_s,
  input  logic [31:0]         dat_out_s,
  output logic                a_cmp,
  output logic                xfr_valid,
  input  logic                xfr_ready,
  output logic [31:0]         xfr_src_addr,
  output logic [31:0]         xfr_blk_addr,
  input  logic                xfr_done,
  input  logic                xfr_err,
  input  logic                err_clr,
  output logic                busy,
  output logic                fetch_err,
  output logic [7:0]          err_cnt
);

  localparam int                  MAX_BD       = BD_SIZE / 2;
  localparam logic [BD_WIDTH-1:0] MAX_BD_W     = BD_WIDTH'(MAX_BD);
  // The counter starts at 0 on entry to a wait state. The timeout is declared on the
  // ACK_TIMEOUT-th consecutive cycle without an acknowledge, so ERR is entered exactly
  // ACK_TIMEOUT cycles after the wait state was entered.
  localparam logic [3:0]          TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_SRC,
    S_WAIT_SRC,
    S_RD_BLK,
    S_WAIT_BLK,
    S_ISSUE,
    S_XFER,
    S_CMPL,
    S_SETTLE,
    S_ERR
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] to_cnt;
  logic       pending;
  logic       timed_out;

  // The whole width of free_bd is compared. A count above MAX_BD is also treated as
  // pending and is not guarded against.
  assign pending   = (free_bd != MAX_BD_W);
  assign timed_out = (to_cnt == TIMEOUT_LAST);

  // NOTE: clocked state uses non-blocking assignments so that every register samples
  // pre-edge values, independent of the order in which the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case statement. That way
  // no path leaves an output unassigned, and no latch is inferred.
  always_comb begin
    state_nxt = state;
    re_s      = 1'b0;
    xfr_valid = 1'b0;
    a_cmp     = 1'b0;
    busy      = 1'b1;
    fetch_err = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (en && pending) state_nxt = S_RD_SRC;
      end
      S_RD_SRC: begin
        re_s      = 1'b1;
        state_nxt = S_WAIT_SRC;
      end
      S_WAIT_SRC: begin
        // If the acknowledge and the timeout arrive in the same cycle, the acknowledge wins.
        if (ack_o_s)        state_nxt = S_RD_BLK;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_RD_BLK: begin
        re_s      = 1'b1;
        state_nxt = S_WAIT_BLK;
      end
      S_WAIT_BLK: begin
        if (ack_o_s)        state_nxt = S_ISSUE;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_ISSUE: begin
        xfr_valid = 1'b1;
        if (xfr_ready) state_nxt = S_XFER;
      end
      S_XFER: begin
        if (xfr_done) state_nxt = S_CMPL;
      end
      S_CMPL: begin
        // The slot is freed even when the transfer failed.
        a_cmp     = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        // This dead cycle lets the store's free_bd pick up the slot just released, so the
        // IDLE check cannot fetch the consumed descriptor a second time.
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        busy      = 1'b0;
        fetch_err = 1'b1;
        if (err_clr) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: acknowledge timeout counter, descriptor word capture, failed-transfer count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt       <= '0;
      xfr_src_addr <= '0;
      xfr_blk_addr <= '0;
      err_cnt      <= '0;
    end else begin
      case (state)
        S_RD_SRC, S_RD_BLK: to_cnt <= '0;
        S_WAIT_SRC: begin
          if (ack_o_s) xfr_src_addr <= dat_out_s;
          else         to_cnt       <= to_cnt + 4'd1;
        end
        S_WAIT_BLK: begin
          if (ack_o_s) xfr_blk_addr <= dat_out_s;
          else         to_cnt       <= to_cnt + 4'd1;
        end
        S_XFER: begin
          if (xfr_done && xfr_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_bd_fetch.sv
// Self-checking bench for sd_bd_fetch.
//
// Inputs are driven 1 ns after each rising edge. Outputs are sampled at the same point,
// which is well away from the next active edge. A table of per-cycle records covers a
// complete single-BD fetch. Hand-written sequences then cover back-to-back BDs, the
// acknowledge timeout, ready back-pressure, failed-transfer saturation, and reset in the
// middle of a transfer.
module tb_sd_bd_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  free_bd = 8'd4;
  logic        re_s;
  logic        ack_o_s = 1'b0;
  logic [31:0] dat_out_s = '0;
  logic        a_cmp;
  logic        xfr_valid;
  logic        xfr_ready = 1'b0;
  logic [31:0] xfr_src_addr;
  logic [31:0] xfr_blk_addr;
  logic        xfr_done = 1'b0;
  logic        xfr_err = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic        fetch_err;
  logic [7:0]  err_cnt;

  int checks  = 0;
  int errors  = 0;
  int re_cnt  = 0;
  int cmp_cnt = 0;

  sd_bd_fetch #(.BD_SIZE(8), .BD_WIDTH(8), .ACK_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .free_bd      (free_bd),
    .re_s         (re_s),
    .ack_o_s      (ack_o_s),
    .dat_out_s    (dat_out_s),
    .a_cmp        (a_cmp),
    .xfr_valid    (xfr_valid),
    .xfr_ready    (xfr_ready),
    .xfr_src_addr (xfr_src_addr),
    .xfr_blk_addr (xfr_blk_addr),
    .xfr_done     (xfr_done),
    .xfr_err      (xfr_err),
    .err_clr      (err_clr),
    .busy         (busy),
    .fetch_err    (fetch_err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  // One table record describes one cycle. The inputs are applied before an edge, and the
  // expected outputs are what the DUT should show just after that edge.
  typedef struct {
    logic        en;
    logic [7:0]  free_bd;
    logic        ack;
    logic [31:0] dat;
    logic        rdy;
    logic        done;
    logic        xerr;
    logic        clr;
    logic        exp_re;
    logic        exp_valid;
    logic        exp_cmp;
    logic        exp_busy;
    logic [31:0] exp_src;
    logic [31:0] exp_blk;
    logic [7:0]  exp_err_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (re_s)  re_cnt++;
    if (a_cmp) cmp_cnt++;
  endtask

  task automatic wait_re(input string name);
    int n;
    n = 0;
    while (!re_s && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(re_s), 32'd1);
  endtask

  // Services one complete descriptor. On entry the caller is idle, and a strobe either is
  // already present or is expected soon.
  task automatic serve_bd(input logic [31:0] src, input logic [31:0] blk,
                          input int rdy_dly, input int done_dly,
                          input logic xerr, input bit bump);
    wait_re("re_s src");
    tick();                                    // WAIT_SRC
    ack_o_s = 1'b1; dat_out_s = src;
    tick();                                    // RD_BLK
    ack_o_s = 1'b0; dat_out_s = '0;
    check("re_s blk", 32'(re_s), 32'd1);
    tick();                                    // WAIT_BLK
    ack_o_s = 1'b1; dat_out_s = blk;
    tick();                                    // ISSUE
    ack_o_s = 1'b0; dat_out_s = '0;
    check("xfr_valid issue", 32'(xfr_valid), 32'd1);
    check("src addr", xfr_src_addr, src);
    check("blk addr", xfr_blk_addr, blk);
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      check("xfr_valid held", 32'(xfr_valid), 32'd1);
      check("src stable", xfr_src_addr, src);
      check("blk stable", xfr_blk_addr, blk);
    end
    xfr_ready = 1'b1;
    tick();                                    // XFER
    xfr_ready = 1'b0;
    check("xfr_valid drop", 32'(xfr_valid), 32'd0);
    repeat (done_dly - 1) tick();
    xfr_done = 1'b1; xfr_err = xerr;
    tick();                                    // CMPL
    xfr_done = 1'b0; xfr_err = 1'b0;
    check("a_cmp pulse", 32'(a_cmp), 32'd1);
    tick();                                    // SETTLE
    check("a_cmp single", 32'(a_cmp), 32'd0);
    // The store sees the freed slot one cycle after a_cmp.
    if (bump) free_bd = free_bd + 8'd1;
  endtask

  initial begin
    int r0;
    int c0;
    int n;

    // Single-BD fetch, one record per cycle. Step 0 also pulses err_clr outside ERR,
    // step 1 acknowledges while still in RD_SRC, and step 3 raises xfr_done outside
    // XFER. All three are expected to be ignored.
    //          en fb     ack dat            rdy don xer clr  re  vld cmp bsy src           blk          ecnt
    vecs[0]  = '{1, 8'd3, 0, 32'h0,         0,  0,  0,  1,   1,  0,  0,  1, 32'h0,        32'h0,       8'd0};
    vecs[1]  = '{1, 8'd3, 1, 32'hDEAD_BEEF, 0,  0,  0,  0,   0,  0,  0,  1, 32'h0,        32'h0,       8'd0};
    vecs[2]  = '{1, 8'd3, 1, 32'h0000_1000, 0,  0,  0,  0,   1,  0,  0,  1, 32'h1000,     32'h0,       8'd0};
    vecs[3]  = '{1, 8'd3, 0, 32'h0,         0,  1,  1,  0,   0,  0,  0,  1, 32'h1000,     32'h0,       8'd0};
    vecs[4]  = '{1, 8'd3, 1, 32'h0000_0020, 0,  0,  0,  0,   0,  1,  0,  1, 32'h1000,     32'h20,      8'd0};
    vecs[5]  = '{1, 8'd3, 0, 32'h0,         1,  0,  0,  0,   0,  0,  0,  1, 32'h1000,     32'h20,      8'd0};
    vecs[6]  = '{1, 8'd3, 0, 32'h0,         0,  0,  0,  0,   0,  0,  0,  1, 32'h1000,     32'h20,      8'd0};
    vecs[7]  = '{1, 8'd3, 0, 32'h0,         0,  0,  0,  0,   0,  0,  0,  1, 32'h1000,     32'h20,      8'd0};
    vecs[8]  = '{1, 8'd3, 0, 32'h0,         0,  0,  0,  0,   0,  0,  0,  1, 32'h1000,     32'h20,      8'd0};
    vecs[9]  = '{1, 8'd3, 0, 32'h0,         0,  0,  0,  0,   0,  0,  0,  1, 32'h1000,     32'h20,      8'd0};
    vecs[10] = '{1, 8'd3, 0, 32'h0,         0,  1,  0,  0,   0,  0,  1,  1, 32'h1000,     32'h20,      8'd0};
    vecs[11] = '{1, 8'd4, 0, 32'h0,         0,  0,  0,  0,   0,  0,  0,  1, 32'h1000,     32'h20,      8'd0};
    vecs[12] = '{1, 8'd4, 0, 32'h0,         0,  0,  0,  0,   0,  0,  0,  0, 32'h1000,     32'h20,      8'd0};
    vecs[13] = '{1, 8'd4, 0, 32'h0,         0,  0,  0,  0,   0,  0,  0,  0, 32'h1000,     32'h20,      8'd0};

    // Reset, then stay idle with nothing pending.
    rst = 1'b0; en = 1'b1; free_bd = 8'd4;
    tick();
    tick();
    check("rst re_s",      32'(re_s),      32'd0);
    check("rst a_cmp",     32'(a_cmp),     32'd0);
    check("rst xfr_valid", 32'(xfr_valid), 32'd0);
    check("rst src",       xfr_src_addr,   32'd0);
    check("rst blk",       xfr_blk_addr,   32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst fetch_err", 32'(fetch_err), 32'd0);
    check("rst err_cnt",   32'(err_cnt),   32'd0);
    rst = 1'b1;
    re_cnt = 0;
    repeat (10) tick();
    check("idle no re_s", 32'(re_cnt), 32'd0);
    check("idle busy",    32'(busy),   32'd0);

    // Table-driven single-BD fetch.
    r0 = re_cnt; c0 = cmp_cnt;
    for (int i = 0; i < 14; i++) begin
      en = vecs[i].en; free_bd = vecs[i].free_bd; ack_o_s = vecs[i].ack;
      dat_out_s = vecs[i].dat; xfr_ready = vecs[i].rdy; xfr_done = vecs[i].done;
      xfr_err = vecs[i].xerr; err_clr = vecs[i].clr;
      tick();
      check($sformatf("v%0d re_s", i),      32'(re_s),      32'(vecs[i].exp_re));
      check($sformatf("v%0d xfr_valid", i), 32'(xfr_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d a_cmp", i),     32'(a_cmp),     32'(vecs[i].exp_cmp));
      check($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].exp_busy));
      check($sformatf("v%0d src", i),       xfr_src_addr,   vecs[i].exp_src);
      check($sformatf("v%0d blk", i),       xfr_blk_addr,   vecs[i].exp_blk);
      check($sformatf("v%0d err_cnt", i),   32'(err_cnt),   32'(vecs[i].exp_err_cnt));
      check($sformatf("v%0d fetch_err", i), 32'(fetch_err), 32'd0);
    end
    ack_o_s = 1'b0; dat_out_s = '0; xfr_ready = 1'b0; xfr_done = 1'b0;
    xfr_err = 1'b0; err_clr = 1'b0;
    check("table re_s total",  32'(re_cnt - r0),  32'd2);
    check("table a_cmp total", 32'(cmp_cnt - c0), 32'd1);

    // Two BDs pending. The bench frees a slot one cycle after each a_cmp.
    free_bd = 8'd2;
    r0 = re_cnt; c0 = cmp_cnt;
    serve_bd(32'h0000_2000, 32'h0000_0040, 0, 3, 1'b0, 1'b1);
    serve_bd(32'h0000_3000, 32'h0000_0041, 0, 3, 1'b0, 1'b1);
    repeat (10) tick();
    check("b2b re_s total",  32'(re_cnt - r0),  32'd4);
    check("b2b a_cmp total", 32'(cmp_cnt - c0), 32'd2);
    check("b2b idle busy",   32'(busy),         32'd0);

    // The second read is never acknowledged, so the acknowledge timeout must fire.
    free_bd = 8'd3;
    c0 = cmp_cnt;
    wait_re("to re_s src");
    tick();
    ack_o_s = 1'b1; dat_out_s = 32'h0000_4000;
    tick();                                    // RD_BLK
    ack_o_s = 1'b0; dat_out_s = '0;
    tick();                                    // first WAIT_BLK cycle
    n = 0;
    while (!fetch_err && n < 40) begin
      tick();
      n++;
    end
    check("timeout cycles", 32'(n),         32'd15);
    check("err busy",       32'(busy),      32'd0);
    r0 = re_cnt;
    repeat (5) tick();
    check("err no re_s",    32'(re_cnt - r0),  32'd0);
    check("err sticky",     32'(fetch_err),    32'd1);
    check("err no a_cmp",   32'(cmp_cnt - c0), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr fetch_err",  32'(fetch_err), 32'd0);
    check("clr busy",       32'(busy),      32'd0);

    // Ready back-pressure, then a failed transfer; the failure count then saturates.
    serve_bd(32'h0000_5000, 32'h0000_0050, 10, 2, 1'b1, 1'b0);
    check("err_cnt one", 32'(err_cnt), 32'd1);
    for (int k = 1; k < 300; k++) serve_bd(32'(k), 32'(k + 7), 0, 1, 1'b1, 1'b0);
    check("err_cnt sat", 32'(err_cnt), 32'd255);

    // Reset during XFER aborts the transfer without issuing a_cmp.
    c0 = cmp_cnt;
    wait_re("rx re_s src");
    tick();
    ack_o_s = 1'b1; dat_out_s = 32'h0000_6000;
    tick();
    ack_o_s = 1'b0; dat_out_s = '0;
    tick();
    ack_o_s = 1'b1; dat_out_s = 32'h0000_0060;
    tick();                                    // ISSUE
    ack_o_s = 1'b0; dat_out_s = '0;
    xfr_ready = 1'b1;
    tick();                                    // XFER
    xfr_ready = 1'b0;
    check("rx busy", 32'(busy), 32'd1);
    rst = 1'b0; xfr_done = 1'b1;
    tick();
    check("rx re_s",      32'(re_s),      32'd0);
    check("rx a_cmp",     32'(a_cmp),     32'd0);
    check("rx xfr_valid", 32'(xfr_valid), 32'd0);
    check("rx src",       xfr_src_addr,   32'd0);
    check("rx blk",       xfr_blk_addr,   32'd0);
    check("rx busy idle", 32'(busy),      32'd0);
    check("rx fetch_err", 32'(fetch_err), 32'd0);
    check("rx err_cnt",   32'(err_cnt),   32'd0);
    rst = 1'b1; xfr_done = 1'b0;
    tick();
    check("rx refetch re_s", 32'(re_s),         32'd1);
    check("rx no a_cmp",     32'(cmp_cnt - c0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
